// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder slice.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_adder_4bit.sv
// Combinational 4-bit adder with carry in/out, shared by the serial controller.
module adder_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                overflow
);

  logic [NIBBLE_W:0] w_full;

  assign w_full   = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(carry_in);
  assign sum      = w_full[NIBBLE_W-1:0];
  assign overflow = w_full[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide unsigned adder that reuses one 4-bit adder, one nibble per clock,
// LSB nibble first, with a start/busy/done handshake.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned NUM_NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          start,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NUM_NIBBLES-1:0] b,
  input  logic                          carry_in,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
  output logic                          overflow
);

  localparam int unsigned W     = NIBBLE_W * NUM_NIBBLES;
  localparam int unsigned SW    = W - NIBBLE_W;
  localparam int unsigned CNT_W = $clog2(NUM_NIBBLES);

  state_t              r_state;
  state_t              w_next;
  logic [W-1:0]        r_a_sh;
  logic [W-1:0]        r_b_sh;
  logic [SW-1:0]       r_sum_sh;
  logic                r_carry;
  logic [CNT_W-1:0]    r_cnt;
  logic [W-1:0]        r_sum;
  logic                r_ovf;
  logic                r_busy;
  logic                r_done;

  logic [NIBBLE_W-1:0] w_nsum;
  logic                w_cout;
  logic                w_last;
  logic                w_accept;
  logic [W-1:0]        w_sum_full;

  adder_4bit u_adder (
    .a        (r_a_sh[NIBBLE_W-1:0]),
    .b        (r_b_sh[NIBBLE_W-1:0]),
    .carry_in (r_carry),
    .sum      (w_nsum),
    .overflow (w_cout)
  );

  assign w_last     = (r_cnt == CNT_W'(NUM_NIBBLES - 1));
  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_sum_full = {w_nsum, r_sum_sh};

  // Next-state logic; DONE accepts a new start back-to-back.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = ADD;
      ADD:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? ADD : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register; busy/done registered from the next state so they track it exactly.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == ADD);
      r_done  <= (w_next == DONE);
    end
  end

  // Operand shifting, carry ripple and result capture on the final nibble.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= carry_in;
      r_cnt   <= '0;
    end else if (r_state == ADD) begin
      r_a_sh   <= r_a_sh >> NIBBLE_W;
      r_b_sh   <= r_b_sh >> NIBBLE_W;
      r_sum_sh <= w_sum_full[W-1:NIBBLE_W];
      r_carry  <= w_cout;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_sum <= w_sum_full;
        r_ovf <= w_cout;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: random and directed additions
// checked against plain a+b+cin arithmetic and the start/busy/done timing.
module tb_nibble_serial_adder;

  localparam int unsigned NN = 4;
  localparam int unsigned W  = 4 * NN;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         overflow;

  nibble_serial_adder #(.NUM_NIBBLES(NN)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [W:0] exp_q[$];
  int         busy_left  = 0;
  bit         exp_done   = 1'b0;
  int         n_accepted = 0;
  logic [W:0] last_res   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a start is taken whenever no addition is in flight;
  // an accepted addition occupies NN cycles, then done is shown for one.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      busy_left = 0;
      exp_done  = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) exp_done = 1'b1;
      end else if (start) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(carry_in));
        busy_left = NN;
        n_accepted++;
      end
    end
  end

  // Monitor: checks handshake every cycle, results on done, hold otherwise.
  always @(negedge clk) begin
    if (!n_rst) begin
      last_res = '0;
    end else begin
      chk("busy", 32'(busy), 32'(busy_left > 0));
      chk("done", 32'(done), 32'(exp_done));
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(exp_q.size()), 32'd1);
        end else begin
          last_res = exp_q.pop_front();
          chk("result", 32'({overflow, sum}), 32'(last_res));
        end
      end else begin
        chk("hold", 32'({overflow, sum}), 32'(last_res));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy_left != 0 || exp_done) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; carry_in = ic;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    wait_idle();
  endtask

  initial begin
    int target;
    int guard;
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_ovf",  32'(overflow), 32'd0);
    n_rst = 1'b1;

    // Directed additions, including full carry ripple.
    issue(16'h1234, 16'h4321, 1'b0);
    issue(16'hFFFF, 16'h0000, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0);

    // Reset in the middle of an addition clears everything at once.
    @(negedge clk);
    start = 1'b1; a = 16'h0F0F; b = 16'h1111; carry_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_ovf",  32'(overflow), 32'd0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    issue(16'h00FF, 16'h0001, 1'b0);

    // Start held high with fresh operands every cycle: back-to-back accepts.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b1;
      a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Random traffic with random gaps.
    target = n_accepted + 1000;
    guard  = 0;
    while (n_accepted < target && guard < 20000) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) != 0);
      a        = W'($urandom);
      b        = W'($urandom);
      carry_in = 1'($urandom);
      guard++;
    end
    if (guard >= 20000) chk("random_timeout", 32'(guard), 32'd0);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("leftover", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
